// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

  localparam int WB_W_DEFAULT     = 32;
  localparam int WB_DEPTH_DEFAULT = 4;
  localparam int WB_PTR_W         = $clog2(WB_DEPTH_DEFAULT);
  localparam int WB_RD_W          = 5;

  // One pending register-file write.
  typedef struct packed {
    logic [WB_RD_W-1:0]      rd;
    logic [WB_W_DEFAULT-1:0] data;
  } wb_entry_t;

  // Register-number match for hazard queries; r0 never matches because
  // writes to it are discarded.
  function automatic logic rd_match(input logic [WB_RD_W-1:0] query,
                                    input logic [WB_RD_W-1:0] rd);
    return (query != '0) && (query == rd);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU and multi-cycle result inputs, register-file write
// port and hazard query lines.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int W = WB_W_DEFAULT
);

  logic               alu_valid;
  logic [WB_RD_W-1:0] alu_rd;
  logic [W-1:0]       alu_data;

  logic               mc_valid;
  logic               mc_ready;
  logic [WB_RD_W-1:0] mc_rd;
  logic [W-1:0]       mc_data;

  logic               RegWrite;
  logic [WB_RD_W-1:0] WbRegNum;
  logic [W-1:0]       WbData;

  logic [WB_RD_W-1:0] q1_num;
  logic [WB_RD_W-1:0] q2_num;
  logic               q1_pend;
  logic               q2_pend;

  // The arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mc_valid, mc_rd, mc_data,
    input  q1_num, q2_num,
    output mc_ready,
    output RegWrite, WbRegNum, WbData,
    output q1_pend, q2_pend
  );

  // The producer / register-file / hazard-unit side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output mc_valid, mc_rd, mc_data,
    output q1_num, q2_num,
    input  mc_ready,
    input  RegWrite, WbRegNum, WbData,
    input  q1_pend, q2_pend
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order circular buffer for multi-cycle results that lost arbitration.
// Every slot's rd and validity are exposed so the hazard compare can see
// the whole queue at once.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  parameter int W     = WB_W_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [WB_RD_W-1:0]              push_rd,
  input  logic [W-1:0]                    push_data,
  input  logic                            pop,
  output logic                            full,
  output logic                            empty,
  output logic [WB_RD_W-1:0]              head_rd,
  output logic [W-1:0]                    head_data,
  output logic [DEPTH-1:0]                entry_valid,
  output logic [DEPTH-1:0][WB_RD_W-1:0]   entry_rd
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic [WB_RD_W-1:0] rd_mem   [DEPTH];
  logic [W-1:0]       data_mem [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full    = (count_reg == CNT_DEPTH);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage write; contents need no reset since validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_mem[wr_ptr_reg]   <= push_rd;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  assign head_rd   = rd_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  // A slot is live when its distance from the read pointer is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset          = PTR_W'(gi) - rd_ptr_reg;
    assign entry_valid[gi] = ({1'b0, offset} < count_reg);
    assign entry_rd[gi]    = rd_mem[gi];
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the register-file write port, gives the
// unstallable ALU path priority, then drains queued multi-cycle results,
// then bypasses a fresh multi-cycle result when nothing is queued.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  parameter int W     = WB_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);

  logic                          fifo_full;
  logic                          fifo_empty;
  logic [WB_RD_W-1:0]            head_rd;
  logic [W-1:0]                  head_data;
  logic [DEPTH-1:0]              entry_valid;
  logic [DEPTH-1:0][WB_RD_W-1:0] entry_rd;

  logic mc_ready;
  logic mc_fire;
  logic alu_take;
  logic mc_live;
  logic pop;
  logic bypass;
  logic push;

  logic               regwrite_reg, regwrite_next;
  logic [WB_RD_W-1:0] wbregnum_reg, wbregnum_next;
  logic [W-1:0]       wbdata_reg,   wbdata_next;

  // Readiness looks only at occupancy so producers never see a
  // combinational path from the ALU or from a same-cycle pop.
  assign mc_ready = !fifo_full;
  assign mc_fire  = bus.mc_valid && mc_ready;

  // r0 results complete their handshake but go nowhere.
  assign alu_take = bus.alu_valid && (bus.alu_rd != '0);
  assign mc_live  = mc_fire && (bus.mc_rd != '0);
  assign pop      = !alu_take && !fifo_empty;
  assign bypass   = !alu_take && fifo_empty && mc_live;
  assign push     = mc_live && !bypass;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_rd     (bus.mc_rd),
    .push_data   (bus.mc_data),
    .pop         (pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Priority select for the next register-file write; idle cycles hold address and data.
  always_comb begin
    regwrite_next = 1'b0;
    wbregnum_next = wbregnum_reg;
    wbdata_next   = wbdata_reg;
    if (alu_take) begin
      regwrite_next = 1'b1;
      wbregnum_next = bus.alu_rd;
      wbdata_next   = bus.alu_data;
    end else if (!fifo_empty) begin
      regwrite_next = 1'b1;
      wbregnum_next = head_rd;
      wbdata_next   = head_data;
    end else if (bypass) begin
      regwrite_next = 1'b1;
      wbregnum_next = bus.mc_rd;
      wbdata_next   = bus.mc_data;
    end
  end

  // Registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_reg <= 1'b0;
      wbregnum_reg <= '0;
      wbdata_reg   <= '0;
    end else begin
      regwrite_reg <= regwrite_next;
      wbregnum_reg <= wbregnum_next;
      wbdata_reg   <= wbdata_next;
    end
  end

  // Hazard query: any live queue slot or the write on the port right now.
  logic [DEPTH-1:0] q1_hit;
  logic [DEPTH-1:0] q2_hit;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_query
    assign q1_hit[gi] = entry_valid[gi] && rd_match(bus.q1_num, entry_rd[gi]);
    assign q2_hit[gi] = entry_valid[gi] && rd_match(bus.q2_num, entry_rd[gi]);
  end

  assign bus.q1_pend = (|q1_hit) || (regwrite_reg && rd_match(bus.q1_num, wbregnum_reg));
  assign bus.q2_pend = (|q2_hit) || (regwrite_reg && rd_match(bus.q2_num, wbregnum_reg));

  assign bus.mc_ready = mc_ready;
  assign bus.RegWrite = regwrite_reg;
  assign bus.WbRegNum = wbregnum_reg;
  assign bus.WbData   = wbdata_reg;

endmodule
